// File: rtl/adam_pause_ctrl.sv
// rtl/adam_pause_ctrl.sv - ordered pause/resume handshake sequencer for downstream targets
module adam_pause_ctrl #(
    parameter int NO_TARGETS = 4,
    parameter int TIMEOUT    = 255,
    localparam int IW        = (NO_TARGETS > 1) ? $clog2(NO_TARGETS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_req,
    output logic                  in_ack,
    output logic [NO_TARGETS-1:0] out_req,
    input  logic [NO_TARGETS-1:0] out_ack,
    output logic                  busy,
    output logic                  timeout_err,
    output logic [IW-1:0]         err_idx
);

    // cnt only needs to reach TIMEOUT; a zero TIMEOUT keeps a 1-bit counter pinned at 0
    localparam int              CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]   CNT_MAX  = CW'(TIMEOUT);
    localparam logic [IW-1:0]   IDX_LAST = IW'(NO_TARGETS - 1);

    typedef enum logic [1:0] {
        IDLE,
        PAUSING,
        PAUSED,
        RESUMING
    } state_t;

    state_t                state, state_n;
    logic [IW-1:0]         idx, idx_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [NO_TARGETS-1:0] out_req_n;
    logic                  in_ack_n;
    logic                  busy_n;
    logic                  timeout_err_n;
    logic [IW-1:0]         err_idx_n;
    logic                  ack_cur;

    // acknowledge of the target currently being handshaked; all others are ignored
    always_comb begin
        ack_cur = 1'b0;
        for (int i = 0; i < NO_TARGETS; i++) begin
            if (idx == IW'(i)) begin
                ack_cur = out_ack[i];
            end
        end
    end

    // sequence control: walk targets upward to pause, downward to resume, track deadlines
    always_comb begin
        state_n       = state;
        idx_n         = idx;
        cnt_n         = cnt;
        timeout_err_n = timeout_err;
        err_idx_n     = err_idx;

        case (state)
            IDLE: begin
                if (in_req) begin
                    state_n = PAUSING;
                    idx_n   = '0;
                    cnt_n   = '0;
                end
            end
            PAUSING: begin
                if (ack_cur) begin
                    cnt_n = '0;
                    if (idx == IDX_LAST) begin
                        state_n = PAUSED;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end else if (cnt != CNT_MAX) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            PAUSED: begin
                if (!in_req) begin
                    state_n = RESUMING;
                    idx_n   = IDX_LAST;
                    cnt_n   = '0;
                end
            end
            RESUMING: begin
                if (!ack_cur) begin
                    cnt_n = '0;
                    if (idx == '0) begin
                        state_n = IDLE;
                    end else begin
                        idx_n = idx - 1'b1;
                    end
                end else if (cnt != CNT_MAX) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = '0;
                cnt_n   = '0;
            end
        endcase

        // the first missed deadline is latched; the sequence itself keeps waiting
        if ((TIMEOUT != 0) && ((state == PAUSING) || (state == RESUMING)) &&
            (cnt == CNT_MAX) && !timeout_err) begin
            timeout_err_n = 1'b1;
            err_idx_n     = idx;
        end

        in_ack_n = (state_n == PAUSED) || (state_n == RESUMING);
        busy_n   = (state_n == PAUSING) || (state_n == RESUMING);

        // requests form a thermometer: targets below idx are held, idx itself follows direction
        out_req_n = '0;
        for (int i = 0; i < NO_TARGETS; i++) begin
            out_req_n[i] = (state_n == PAUSED) ||
                           ((state_n == PAUSING)  && (IW'(i) <= idx_n)) ||
                           ((state_n == RESUMING) && (IW'(i) <  idx_n));
        end
    end

    // registered state and outputs; reset drops every request immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            out_req     <= '0;
            in_ack      <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            err_idx     <= '0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            cnt         <= cnt_n;
            out_req     <= out_req_n;
            in_ack      <= in_ack_n;
            busy        <= busy_n;
            timeout_err <= timeout_err_n;
            err_idx     <= err_idx_n;
        end
    end

endmodule
